// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder/subtractor. One 1-bit full adder is stepped over the
//   operands LSB first, taking WIDTH cycles for each operation.
//
//   Parameters
//     WIDTH  operand/result width in bits (2..32)
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     start  begin an operation (sampled only in IDLE)
//     sub    0 = A + B, 1 = A - B (sampled with start)
//     A, B   operands (sampled with start)
//     busy   high while bits are being processed
//     done   one-cycle completion pulse
//     S      registered result
//     c_out  registered carry-out (add) / not-borrow (sub)
//     ovf    registered two's-complement signed overflow
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] w_sh;
  logic             carry;

  logic fa_a;
  logic fa_b;
  logic fa_s;
  logic fa_c;
  logic last_bit;

  // Single full adder fed from the LSBs of the operand shift registers.
  always_comb begin
    fa_a     = a_sh[0];
    fa_b     = b_sh[0];
    fa_s     = fa_a ^ fa_b ^ carry;
    fa_c     = (fa_a & fa_b) | (fa_a & carry) | (fa_b & carry);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Subtraction is A + ~B + 1: B is inverted on capture and the
  // carry flop is seeded with sub. At the MSB step, carry still holds the
  // carry into the MSB, so carry ^ fa_c is the signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      w_sh  <= '0;
      carry <= 1'b0;
      S     <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= sub ? ~B : B;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          w_sh  <= {fa_s, w_sh[WIDTH-1:1]};
          carry <= fa_c;
          if (last_bit) begin
            S     <= {fa_s, w_sh[WIDTH-1:1]};
            c_out <= fa_c;
            ovf   <= carry ^ fa_c;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Self-checking bench for serial_add_ctrl at WIDTH=8. Expected results are
//   computed with native arithmetic, queued when an operation is launched and
//   popped when done is observed.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         c_out;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  // {ovf, c_out, S}
  logic [W+1:0] exp_q[$];
  logic [W-1:0] last_s;
  logic         last_c;
  logic         last_v;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic s);
    logic [W:0]   r;
    logic         v;
    if (s) begin
      r = {1'b0, a} + {1'b0, ~b} + 9'd1;
      v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r = {1'b0, a} + {1'b0, b};
      v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {v, r[W], r[W-1:0]};
  endfunction

  // Launch one operation and follow it edge by edge to completion.
  // hold: keep start high throughout; mid: pulse start with new operands at E3.
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input bit hold, input bit mid);
    logic [W+1:0] e;
    A = a; B = b; sub = s; start = 1'b1;
    exp_q.push_back(model(a, b, s));
    @(posedge clk); #1;  // E0
    if (!hold) start = 1'b0;
    A = ~a; B = a ^ 8'h5A; sub = ~s;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL accept busy/done got=%b%b want=10", busy, done);
    end
    for (int cyc = 1; cyc <= 9; cyc++) begin
      if (mid && cyc == 3) begin
        start = 1'b1; A = 8'hAA; B = 8'h33;
      end
      @(posedge clk); #1;
      if (mid && cyc == 3 && !hold) start = 1'b0;
      if (cyc < 8) begin
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || S !== last_s || c_out !== last_c || ovf !== last_v) begin
          bad++;
          $display("FAIL run_hold cyc=%0d busy=%b done=%b S=%h c=%b v=%b want busy=1 done=0 S=%h c=%b v=%b",
                   cyc, busy, done, S, c_out, ovf, last_s, last_c, last_v);
        end
      end else if (cyc == 8) begin
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
          bad++;
          $display("FAIL done_pulse busy/done got=%b%b want=01", busy, done);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard empty at done");
        end else begin
          e = exp_q.pop_front();
          if ({ovf, c_out, S} !== e) begin
            bad++;
            $display("FAIL result a=%h b=%h sub=%b got S=%h c=%b v=%b want S=%h c=%b v=%b",
                     a, b, s, S, c_out, ovf, e[W-1:0], e[W], e[W+1]);
          end
          last_s = e[W-1:0]; last_c = e[W]; last_v = e[W+1];
        end
      end else begin
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          bad++;
          $display("FAIL back_to_idle busy/done got=%b%b want=00", busy, done);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    last_s = '0; last_c = 1'b0; last_v = 1'b0;
    #1;
    total++;
    if ({busy, done, S, c_out, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b S=%h c=%b v=%b want all 0", busy, done, S, c_out, ovf);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_start busy/done got=%b%b want=00", busy, done);
    end
  endtask

  task automatic test_add();
    drive_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
    drive_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    drive_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    drive_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    drive_op(8'h05, 8'h07, 1'b1, 1'b0, 1'b0);
    drive_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
    drive_op(8'h42, 8'h42, 1'b1, 1'b0, 1'b0);
    drive_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      drive_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start();
    drive_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL no_second_op busy/done got=%b%b want=00", busy, done);
    end
  endtask

  task automatic test_reset_midrun();
    A = 8'h3C; B = 8'h0F; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;  // E0
    start = 1'b0;
    repeat (4) @(posedge clk);  // E1..E4
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, S, c_out, ovf} !== '0) begin
      bad++;
      $display("FAIL midrun_reset got busy=%b done=%b S=%h c=%b v=%b want all 0", busy, done, S, c_out, ovf);
    end
    last_s = '0; last_c = 1'b0; last_v = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL aborted_no_done cyc=%0d busy/done got=%b%b want=00", i, busy, done);
      end
    end
    rst_n = 1'b1;
    drive_op(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive_op(8'h01, 8'h02, 1'b0, 1'b1, 1'b0);
    drive_op(8'hF0, 8'h10, 1'b1, 1'b1, 1'b0);
    drive_op(8'h7F, 8'h7F, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stop busy got=%b want=0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_random();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 sub  input  1  0 = add, 1 = subtract (A - B); sampled with start.
REQ-006 A  input  WIDTH  operand A; sampled with start.
REQ-007 B  input  WIDTH  operand B; sampled with start.
REQ-008 busy  output  1  high while bits are being processed (RUN state).
REQ-009 done  output  1  one-cycle completion pulse (DONE state).
REQ-010 S  output  WIDTH  registered result.
REQ-011 c_out  output  1  registered carry-out (add) / not-borrow (sub).
REQ-012 ovf  output  1  registered two's-complement signed overflow.

Function
REQ-013 The block SHALL sequence one internal 1-bit full adder (S = a^b^c, c_out = ab|ac|bc) over WIDTH cycles, LSB first.
REQ-014 FSM states SHALL be IDLE, RUN and DONE; IDLE->RUN on start=1, RUN->DONE after bit WIDTH-1, DONE->IDLE unconditionally next edge.
REQ-015 On the accepting edge E0: latch A; latch B (inverted when sub=1); set carry flop to sub; clear bit counter; enter RUN.
REQ-016 Edges E1..E_WIDTH SHALL each process bit i = E-1: full-adder sum into working shift register, carry flop updated.
REQ-017 At E_WIDTH: S, c_out and ovf SHALL load from working register, final carry, and (carry into MSB XOR carry out of MSB).
REQ-018 busy SHALL be 1 exactly from after E0 until E_WIDTH (WIDTH cycles); done SHALL be 1 exactly for the cycle after E_WIDTH.
REQ-019 Latency: done high WIDTH+1 edges after the start-accepting edge; throughput one operation per WIDTH+2 cycles.
REQ-020 start in RUN or DONE SHALL be ignored (not queued); A, B, sub changes after E0 SHALL not affect the operation.
REQ-021 S, c_out, ovf SHALL hold their last values through IDLE and the next RUN until the next E_WIDTH update.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; sub result = A + ~B + 1; c_out=1 in sub means A >= B unsigned.
REQ-023 Bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL not wrap past WIDTH-1.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE and busy, done, S, c_out, ovf, counter, carry and working registers to 0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first start after rst_n rises SHALL run normally.
REQ-026 start high on the first edge after reset release SHALL be accepted.

Verification (WIDTH=8)
REQ-027 add A=0x0F, B=0x01 -> busy 8 cycles, done at E9, S=0x10, c_out=0, ovf=0.
REQ-028 add A=0xFF, B=0x01 -> S=0x00, c_out=1, ovf=0; add A=0x7F, B=0x01 -> S=0x80, c_out=0, ovf=1.
REQ-029 sub A=0x05, B=0x07 -> S=0xFE, c_out=0, ovf=0; sub A=0x80, B=0x01 -> S=0x7F, c_out=1, ovf=1.
REQ-030 start pulsed at E3 of a running add with new A/B -> original result delivered at E9, no second operation, done single pulse.
REQ-031 rst_n low between E4 and E5 -> all outputs 0 at once, no done; new start after release -> correct result at its own E9.
REQ-032 start held high continuously -> operations accepted every 10 cycles, S/c_out/ovf stable between completions.
